// File: rtl/fp_cvt_seq_if.sv
// Request/response bundle for the sequential fcvt unit.
// The requester drives the operand and request fields; the converter
// drives back result, flags, ready and busy.
interface fp_cvt_seq_if;
    logic        enable;
    logic [31:0] data;
    logic [2:0]  rm;
    logic [1:0]  op;
    logic        i2f;
    logic        f2i;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
    logic        busy;

    modport master (
        output enable, data, rm, op, i2f, f2i,
        input  result, flags, ready, busy
    );

    modport slave (
        input  enable, data, rm, op, i2f, f2i,
        output result, flags, ready, busy
    );
endinterface

// File: rtl/fp_cvt_seq.sv
// Sequential int32 <-> float32 converter.
// One shift per cycle in NORM, a single rounding step in ROUND, and a
// one-cycle DONE state that presents the ready pulse. Special operands
// (zero, NaN, infinities, out-of-range exponents) and invalid requests
// skip straight to DONE.
module fp_cvt_seq #(
    parameter int unsigned RCAP = 25
) (
    input  logic        clock,
    input  logic        reset,
    fp_cvt_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam logic [7:0] RCAP_K = RCAP[7:0];

    state_t      state;
    logic [31:0] mag;
    logic        guard_q;
    logic        sticky_q;
    logic [7:0]  exp_q;
    logic [7:0]  cnt;
    logic        sign_q;
    logic        unsigned_q;
    logic        is_i2f;
    logic        shift_left;
    logic [2:0]  rm_q;
    logic [31:0] result_q;
    logic [4:0]  flags_q;
    logic        ready_q;
    logic        busy_q;

    // op[1] carries no meaning for this unit
    logic unused_op1;
    assign unused_op1 = bus.op[1];

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;

    // Request decode: classify the incoming operand and prepare the
    // initial shifter contents for either direction.
    logic [7:0]  d_exp;
    logic [22:0] d_frac;
    logic [7:0]  d_exp_eff;
    logic [23:0] d_sig;
    logic        d_zero;
    logic        d_nan;
    logic        d_ovr;
    logic [31:0] sat_pos;
    logic [31:0] sat_neg;
    logic        d_left;
    logic [7:0]  d_k;
    logic        i_neg;
    logic [31:0] i_mag;

    always_comb begin
        d_exp     = bus.data[30:23];
        d_frac    = bus.data[22:0];
        d_exp_eff = (d_exp == 8'd0) ? 8'd1 : d_exp;
        d_sig     = {d_exp != 8'd0, d_frac};
        d_zero    = (bus.data[30:0] == 31'd0);
        d_nan     = (d_exp == 8'hFF) && (d_frac != 23'd0);
        d_ovr     = (d_exp >= 8'd159);
        sat_pos   = bus.op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        sat_neg   = bus.op[0] ? 32'h0000_0000 : 32'h8000_0000;
        d_left    = (d_exp_eff > 8'd150);
        if (d_left)
            d_k = d_exp_eff - 8'd150;
        else if ((8'd150 - d_exp_eff) > RCAP_K)
            d_k = RCAP_K;
        else
            d_k = 8'd150 - d_exp_eff;
        i_neg = bus.data[31] & ~bus.op[0];
        i_mag = i_neg ? (~bus.data + 32'd1) : bus.data;
    end

    // Rounding and range check on the aligned magnitude held in ROUND.
    // i2f takes guard/sticky from the low byte of the normalised value;
    // f2i takes them from the bits shifted out during alignment.
    logic        r_lsb;
    logic        r_g;
    logic        r_s;
    logic        r_inc;
    logic        r_nx;
    logic [23:0] r_frac;
    logic [7:0]  r_exp;
    logic [32:0] r_mag;
    logic [31:0] r_result;
    logic [4:0]  r_flags;

    always_comb begin
        if (is_i2f) begin
            r_lsb = mag[8];
            r_g   = mag[7];
            r_s   = |mag[6:0];
        end else begin
            r_lsb = mag[0];
            r_g   = guard_q;
            r_s   = sticky_q;
        end
        case (rm_q)
            3'b001:  r_inc = 1'b0;
            3'b010:  r_inc = sign_q & (r_g | r_s);
            3'b011:  r_inc = ~sign_q & (r_g | r_s);
            3'b100:  r_inc = r_g;
            default: r_inc = r_g & (r_s | r_lsb);
        endcase
        r_nx     = r_g | r_s;
        r_frac   = {1'b0, mag[30:8]} + {23'd0, r_inc};
        r_exp    = exp_q + {7'd0, r_frac[23]};
        r_mag    = {1'b0, mag} + {32'd0, r_inc};
        r_result = '0;
        r_flags  = '0;
        if (is_i2f) begin
            // a mantissa carry leaves r_frac[22:0] at zero already
            r_result = {sign_q, r_exp, r_frac[22:0]};
            r_flags  = {4'b0000, r_nx};
        end else if (!unsigned_q) begin
            if (!sign_q && (r_mag > 33'h0_7FFF_FFFF)) begin
                r_result = 32'h7FFF_FFFF;
                r_flags  = 5'b10000;
            end else if (sign_q && (r_mag > 33'h0_8000_0000)) begin
                r_result = 32'h8000_0000;
                r_flags  = 5'b10000;
            end else begin
                r_result = sign_q ? (~r_mag[31:0] + 32'd1) : r_mag[31:0];
                r_flags  = {4'b0000, r_nx};
            end
        end else begin
            if (sign_q && (r_mag != 33'd0)) begin
                r_result = 32'h0000_0000;
                r_flags  = 5'b10000;
            end else if (sign_q) begin
                r_result = 32'h0000_0000;
                r_flags  = {4'b0000, r_nx};
            end else if (r_mag[32]) begin
                r_result = 32'hFFFF_FFFF;
                r_flags  = 5'b10000;
            end else begin
                r_result = r_mag[31:0];
                r_flags  = {4'b0000, r_nx};
            end
        end
    end

    // Control FSM with the shifter datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mag        <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            exp_q      <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            unsigned_q <= 1'b0;
            is_i2f     <= 1'b0;
            shift_left <= 1'b0;
            rm_q       <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.enable) begin
                        rm_q       <= bus.rm;
                        unsigned_q <= bus.op[0];
                        is_i2f     <= bus.i2f;
                        guard_q    <= 1'b0;
                        sticky_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.i2f == bus.f2i) begin
                            state    <= DONE;
                            ready_q  <= 1'b1;
                            result_q <= '0;
                            flags_q  <= '0;
                        end else if (bus.i2f) begin
                            if (bus.data == 32'd0) begin
                                state    <= DONE;
                                ready_q  <= 1'b1;
                                result_q <= '0;
                                flags_q  <= '0;
                            end else begin
                                state  <= NORM;
                                mag    <= i_mag;
                                sign_q <= i_neg;
                                exp_q  <= 8'd158;
                            end
                        end else if (d_zero) begin
                            state    <= DONE;
                            ready_q  <= 1'b1;
                            result_q <= '0;
                            flags_q  <= '0;
                        end else if (d_nan) begin
                            state    <= DONE;
                            ready_q  <= 1'b1;
                            result_q <= sat_pos;
                            flags_q  <= 5'b10000;
                        end else if (d_ovr) begin
                            state    <= DONE;
                            ready_q  <= 1'b1;
                            result_q <= bus.data[31] ? sat_neg : sat_pos;
                            flags_q  <= 5'b10000;
                        end else begin
                            state      <= NORM;
                            mag        <= {8'd0, d_sig};
                            sign_q     <= bus.data[31];
                            cnt        <= d_k;
                            shift_left <= d_left;
                        end
                    end
                end
                NORM: begin
                    if (is_i2f) begin
                        if (mag[31]) begin
                            state <= ROUND;
                        end else begin
                            mag   <= {mag[30:0], 1'b0};
                            exp_q <= exp_q - 8'd1;
                        end
                    end else if (cnt == 8'd0) begin
                        state <= ROUND;
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (shift_left) begin
                            mag <= {mag[30:0], 1'b0};
                        end else begin
                            mag      <= {1'b0, mag[31:1]};
                            guard_q  <= mag[0];
                            sticky_q <= sticky_q | guard_q;
                        end
                    end
                end
                ROUND: begin
                    state    <= DONE;
                    ready_q  <= 1'b1;
                    result_q <= r_result;
                    flags_q  <= r_flags;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_cvt_seq.sv
// Directed bench for fp_cvt_seq: the driver queues hand-computed expected
// responses; a negedge monitor pops them on each ready pulse and checks
// result, flags and latency, plus busy against a cycle model.
module tb_fp_cvt_seq;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic clock;
    logic reset;
    fp_cvt_seq_if bus ();

    fp_cvt_seq #(.RCAP(25)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   free_edge = 0;
    int   last_acc = 32'h7FFF_FFFF;
    bit   chk_busy = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
        end
    endtask

    // Monitor: response scoreboard, timeout watch and busy model check.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got result 0x%08h with no request outstanding", bus.result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, " result"}, bus.result, e.res);
                    check({e.name, " flags"}, {27'd0, bus.flags}, {27'd0, e.flg});
                    check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end else if (sb.size() != 0 && cyc > sb[0].acc + sb[0].lat + 3) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: no ready by cycle %0d, expected at %0d", e.name, cyc, e.acc + e.lat - 1);
            end
            if (chk_busy)
                check("busy", {31'd0, bus.busy},
                      {31'd0, (cyc >= last_acc) && (cyc <= free_edge - 2)});
        end
    end

    task automatic drive(input logic [31:0] d, input logic [2:0] r, input logic [1:0] o,
                         input logic i, input logic f);
        bus.data   = d;
        bus.rm     = r;
        bus.op     = o;
        bus.i2f    = i;
        bus.f2i    = f;
        bus.enable = 1'b1;
    endtask

    task automatic wait_free();
        @(negedge clock);
        while (cyc + 1 < free_edge) @(negedge clock);
    endtask

    task automatic push(input logic [31:0] er, input logic [4:0] ef, input int el, input string nm);
        exp_t e;
        e.res  = er;
        e.flg  = ef;
        e.lat  = el;
        e.acc  = cyc + 1;
        e.name = nm;
        sb.push_back(e);
        last_acc  = cyc + 1;
        free_edge = cyc + 1 + el + 1;
    endtask

    task automatic issue(input logic [31:0] d, input logic [2:0] r, input logic [1:0] o,
                         input logic i, input logic f, input logic [31:0] er,
                         input logic [4:0] ef, input int el, input string nm);
        wait_free();
        drive(d, r, o, i, f);
        push(er, ef, el, nm);
        @(negedge clock);
        bus.enable = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.data   = '0;
        bus.rm     = '0;
        bus.op     = '0;
        bus.i2f    = 1'b0;
        bus.f2i    = 1'b0;
        repeat (3) @(negedge clock);
        check("reset result", bus.result, 32'h0);
        check("reset flags", {27'd0, bus.flags}, 32'h0);
        check("reset ready", {31'd0, bus.ready}, 32'h0);
        check("reset busy", {31'd0, bus.busy}, 32'h0);
        reset    = 1'b0;
        chk_busy = 1'b1;

        // nonzero result first so the mid-operation reset has something to clear
        issue(32'h7FFF_FFFF, RNE, 2'b00, 1, 0, 32'h4F00_0000, 5'b00001, 4, "i2f_7fffffff_rne");

        // reset in the middle of NORM: request dropped, outputs cleared at once
        wait_free();
        chk_busy = 1'b0;
        drive(32'h0000_0001, RNE, 2'b00, 1, 0);
        @(negedge clock);
        bus.enable = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset result", bus.result, 32'h0);
        check("midreset flags", {27'd0, bus.flags}, 32'h0);
        check("midreset ready", {31'd0, bus.ready}, 32'h0);
        check("midreset busy", {31'd0, bus.busy}, 32'h0);
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        free_edge = 0;
        last_acc  = 32'h7FFF_FFFF;
        chk_busy  = 1'b1;
        repeat (40) @(negedge clock);

        // int -> float
        issue(32'h0000_0001, RNE, 2'b00, 1, 0, 32'h3F80_0000, 5'b00000, 34, "i2f_1");
        issue(32'h8000_0000, RNE, 2'b00, 1, 0, 32'hCF00_0000, 5'b00000, 3, "i2f_min_int");
        issue(32'h7FFF_FFFF, RTZ, 2'b00, 1, 0, 32'h4EFF_FFFF, 5'b00001, 4, "i2f_7fffffff_rtz");
        issue(32'hFFFF_FFFF, RNE, 2'b01, 1, 0, 32'h4F80_0000, 5'b00001, 3, "i2f_u_ffffffff");
        issue(32'h0000_0000, RNE, 2'b00, 1, 0, 32'h0000_0000, 5'b00000, 1, "i2f_zero");

        // float -> int, rounding of 2.5 (k = 22)
        issue(32'h4020_0000, RNE, 2'b00, 0, 1, 32'h0000_0002, 5'b00001, 25, "f2i_2p5_rne");
        issue(32'h4020_0000, RMM, 2'b00, 0, 1, 32'h0000_0003, 5'b00001, 25, "f2i_2p5_rmm");
        issue(32'h4020_0000, RUP, 2'b00, 0, 1, 32'h0000_0003, 5'b00001, 25, "f2i_2p5_rup");
        issue(32'h4020_0000, RTZ, 2'b00, 0, 1, 32'h0000_0002, 5'b00001, 25, "f2i_2p5_rtz");
        issue(32'h4020_0000, RDN, 2'b00, 0, 1, 32'h0000_0002, 5'b00001, 25, "f2i_2p5_rdn");
        issue(32'h4020_0000, 3'b110, 2'b00, 0, 1, 32'h0000_0002, 5'b00001, 25, "f2i_2p5_rm6");
        issue(32'h3F80_0000, RNE, 2'b00, 0, 1, 32'h0000_0001, 5'b00000, 26, "f2i_1p0");
        issue(32'hBFC0_0000, RNE, 2'b00, 0, 1, 32'hFFFF_FFFE, 5'b00001, 26, "f2i_m1p5");

        // float -> int, specials and range limits
        issue(32'hBF80_0000, RNE, 2'b01, 0, 1, 32'h0000_0000, 5'b10000, 26, "f2i_u_m1p0");
        issue(32'h7FC0_0000, RNE, 2'b00, 0, 1, 32'h7FFF_FFFF, 5'b10000, 1, "f2i_nan");
        issue(32'hFF80_0000, RNE, 2'b01, 0, 1, 32'h0000_0000, 5'b10000, 1, "f2i_u_minf");
        issue(32'h7F80_0000, RNE, 2'b00, 0, 1, 32'h7FFF_FFFF, 5'b10000, 1, "f2i_pinf");
        issue(32'h8000_0000, RNE, 2'b00, 0, 1, 32'h0000_0000, 5'b00000, 1, "f2i_mzero");
        issue(32'hCF00_0000, RNE, 2'b00, 0, 1, 32'h8000_0000, 5'b00000, 11, "f2i_m2p31");
        issue(32'h4F00_0000, RNE, 2'b00, 0, 1, 32'h7FFF_FFFF, 5'b10000, 11, "f2i_2p31_ovf");
        issue(32'h4F00_0000, RNE, 2'b01, 0, 1, 32'h8000_0000, 5'b00000, 11, "f2i_u_2p31");
        issue(32'h4F7F_FFFF, RNE, 2'b01, 0, 1, 32'hFFFF_FF00, 5'b00000, 11, "f2i_u_max");

        // subnormal inputs: alignment capped at 25 right shifts
        issue(32'h0000_0001, RUP, 2'b00, 0, 1, 32'h0000_0001, 5'b00001, 28, "f2i_sub_rup");
        issue(32'h0000_0001, RDN, 2'b00, 0, 1, 32'h0000_0000, 5'b00001, 28, "f2i_sub_rdn");
        issue(32'h8000_0001, RDN, 2'b00, 0, 1, 32'hFFFF_FFFF, 5'b00001, 28, "f2i_msub_rdn");
        issue(32'h8000_0001, RDN, 2'b01, 0, 1, 32'h0000_0000, 5'b10000, 28, "f2i_u_msub_rdn");
        issue(32'h8000_0001, RNE, 2'b01, 0, 1, 32'h0000_0000, 5'b00001, 28, "f2i_u_msub_rne");

        // invalid requests
        issue(32'h1234_5678, RNE, 2'b00, 1, 1, 32'h0000_0000, 5'b00000, 1, "both_set");
        issue(32'h1234_5678, RNE, 2'b00, 0, 0, 32'h0000_0000, 5'b00000, 1, "none_set");

        // enable held high with alternating requests: only idle-time ones answered
        wait_free();
        for (int t = 0; t < 24; t++) begin
            int ed;
            ed = cyc + 1;
            if (ed[0]) begin
                drive(32'h1234_5678, RNE, 2'b00, 1, 1);
                if (ed >= free_edge) push(32'h0000_0000, 5'b00000, 1, "stream_invalid");
            end else begin
                drive(32'h8000_0000, RNE, 2'b00, 1, 0);
                if (ed >= free_edge) push(32'hCF00_0000, 5'b00000, 3, "stream_i2f");
            end
            @(negedge clock);
        end
        bus.enable = 1'b0;

        // drain with a bound
        for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clock);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
